conv_sequencer: RTL
===================

// Module: conv_sequencer
// PURPOSE
//   Session controller for the hex-entry -> IEEE754 conversion path.
//   Counts entered digits, launches the converter on confirm, watches for done/error/timeout,
//   and latches the result. Selects the word and mask for the segment controller.
//   Replaces the ad hoc input/output/error/reset always-blocks in the top level.
//   Sits between the debouncer pulses, shift register, converter fsm and segment_controller.
// PARAMETERS
//   DIGITS_MAX     4        max digits counted; converter input is 16 bits = 4 hex digits
//   TIMEOUT_CYCLES 1024     BUSY cycles allowed before declaring fault (>=2)
//   SHOW_MASK      8'hF0    mask driven to display while in SHOW
// PORTS
//   clk            in   1   system clock
//   reset          in   1   asynchronous, active-high reset
//   enter_pulse    in   1   one-cycle debounced enter strobe
//   confirm_pulse  in   1   one-cycle debounced confirm strobe
//   clear_pulse    in   1   one-cycle debounced user reset strobe
//   entry_word     in   32  shift register contents
//   entry_mask     in   8   shift register digit mask
//   conv_done      in   1   converter result valid (R_O)
//   conv_error     in   1   converter error flag
//   conv_result    in   16  converter result
//   conv_start     out  1   one-cycle start strobe to converter (R_I)
//   conv_data      out  16  operand held stable from START until next clear
//   conv_reset     out  1   one-cycle converter reset strobe
//   show_word      out  32  word to segment controller
//   show_mask      out  8   mask to segment controller
//   error          out  1   sticky error indicator
//   busy           out  1   1 in START and BUSY
//   state          out  3   current state encoding, debug
// BEHAVIOUR
//   - All outputs registered. On reset: state=IDLE, every output 0, digit_cnt=0, timer=0.
//   - States: IDLE=0, ENTRY=1, START=2, BUSY=3, SHOW=4, FAULT=5. Codes 6-7 go to IDLE next cycle.
//   - Priority within any state: clear_pulse > conv_error > conv_done/timeout > confirm > enter.
//   - clear_pulse, any state: next state IDLE; conv_reset=1 for exactly one cycle.
//     error, show_word, conv_data, digit_cnt and timer are all cleared. conv_start is forced to 0.
//   - IDLE/ENTRY:
//     - show_word<=entry_word and show_mask<=entry_mask every cycle (1-cycle latency).
//     - enter_pulse: digit_cnt++, saturating at DIGITS_MAX. IDLE->ENTRY on first enter.
//   - ENTRY + confirm_pulse, with digit_cnt>=1: conv_data<=entry_word[15:0] -> START.
//     confirm in IDLE is ignored.
//   - START (1 cycle): conv_start=1, timer=0 -> BUSY. conv_start is 0 in every other state.
//   - BUSY:
//     - timer increments every cycle.
//     - conv_error=1 -> FAULT, error<=1. Error wins over a same-cycle conv_done.
//     - conv_done=1 -> SHOW. show_word<={16'h0,conv_result}, show_mask<=SHOW_MASK.
//     - timer==TIMEOUT_CYCLES-1 with no done/error -> FAULT, error<=1.
//       A done in that same cycle wins over the timeout.
//     - enter/confirm are ignored.
//   - SHOW and FAULT: hold show_word/show_mask, ignore enter/confirm/done/error; leave only on clear.
//     In FAULT the error flag stays 1.
//   - conv_done/conv_error outside BUSY are ignored and leave no trace.
//   - Async reset mid-conversion: immediate IDLE. No conv_reset pulse; the converter uses the same reset.
//   - Timer width $clog2(TIMEOUT_CYCLES+1). It never wraps, because exit is forced at TIMEOUT_CYCLES-1.
// TESTING
//   1 Enter 4 digits with entry_word=32'h0000_3C00, then confirm.
//     -> conv_start high 1 cycle, conv_data=16'h3C00, busy=1.
//     Then conv_done with result 16'h3F80 -> show_word=32'h0000_3F80, show_mask=8'hF0.
//   2 Confirm with zero digits entered -> stays IDLE, conv_start never asserts.
//     Further enters beyond 4 keep digit_cnt=4.
//   3 In BUSY, drive conv_error and conv_done in the same cycle -> FAULT, error=1.
//     Next clear_pulse -> IDLE, error=0, conv_reset high exactly 1 cycle.
//   4 TIMEOUT_CYCLES=8, no done after start -> FAULT 8 cycles after entering BUSY, error=1.
//     Done arriving on the 8th cycle -> SHOW instead.
//   5 clear_pulse together with confirm in ENTRY -> IDLE, no conv_start.
//     Async reset asserted in BUSY -> all outputs 0 immediately.
//   6 In SHOW, pulse enter/confirm/conv_done with a new result -> show_word unchanged, state stays 4.

Source files
------------

// File: rtl/conv_sequencer_if.sv
// conv_sequencer_if
//   Handshake bundle between the conversion session controller and the hex->IEEE754
//   converter FSM.
//   Signals:
//     conv_start   controller -> converter  one-cycle start strobe (R_I)
//     conv_data    controller -> converter  16-bit operand, stable from start until clear
//     conv_reset   controller -> converter  one-cycle converter reset strobe
//     conv_done    converter -> controller  result valid (R_O)
//     conv_error   converter -> controller  conversion error flag
//     conv_result  converter -> controller  16-bit result
//   Modports: master = session controller side, slave = converter side.
interface conv_sequencer_if;
   logic        conv_start;
   logic [15:0] conv_data;
   logic        conv_reset;
   logic        conv_done;
   logic        conv_error;
   logic [15:0] conv_result;

   modport master (
      output conv_start, conv_data, conv_reset,
      input  conv_done, conv_error, conv_result
   );

   modport slave (
      input  conv_start, conv_data, conv_reset,
      output conv_done, conv_error, conv_result
   );
endinterface

// File: rtl/conv_sequencer.sv
// conv_sequencer
//   Session controller for the hex-entry -> IEEE754 conversion path. Counts entered digits,
//   launches the converter on confirm, watches for done/error/timeout, latches the result and
//   selects the word/mask shown by the segment controller.
//   Ports:
//     clk            system clock
//     reset          asynchronous, active-high reset
//     enter_pulse    one-cycle debounced enter strobe
//     confirm_pulse  one-cycle debounced confirm strobe
//     clear_pulse    one-cycle debounced user reset strobe
//     entry_word     shift register contents (32 bits)
//     entry_mask     shift register digit mask (8 bits)
//     conv           converter handshake (master side of conv_sequencer_if)
//     show_word      word to segment controller
//     show_mask      mask to segment controller
//     error          sticky error indicator
//     busy           high while a conversion is being launched or awaited
//     state          current state code, debug (IDLE=0 ENTRY=1 START=2 BUSY=3 SHOW=4 FAULT=5)
//   All outputs are registered.
module conv_sequencer #(
   parameter int unsigned DIGITS_MAX     = 4,
   parameter int unsigned TIMEOUT_CYCLES = 1024,
   parameter logic [7:0]  SHOW_MASK      = 8'hF0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enter_pulse,
   input  logic             confirm_pulse,
   input  logic             clear_pulse,
   input  logic [31:0]      entry_word,
   input  logic [7:0]       entry_mask,
   conv_sequencer_if.master conv,
   output logic [31:0]      show_word,
   output logic [7:0]       show_mask,
   output logic             error,
   output logic             busy,
   output logic [2:0]       state
);

   localparam int unsigned CntW = $clog2(DIGITS_MAX + 1);
   localparam int unsigned TmrW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CntW-1:0] CntMax  = CntW'(DIGITS_MAX);
   localparam logic [TmrW-1:0] TmrLast = TmrW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {
      StIdle  = 3'd0,
      StEntry = 3'd1,
      StStart = 3'd2,
      StBusy  = 3'd3,
      StShow  = 3'd4,
      StFault = 3'd5
   } state_e;

   state_e          state_q, state_d;
   logic [CntW-1:0] digit_cnt_q, digit_cnt_d;
   logic [TmrW-1:0] timer_q, timer_d;
   logic [15:0]     conv_data_q, conv_data_d;
   logic [31:0]     show_word_q, show_word_d;
   logic [7:0]      show_mask_q, show_mask_d;
   logic            error_q, error_d;
   logic            busy_q, busy_d;
   logic            conv_start_q, conv_start_d;
   logic            conv_reset_q, conv_reset_d;

   logic            confirm_ok;
   logic            timeout;

   // ENTRY is only reachable through an enter, so the digit check is a safety net.
   assign confirm_ok = confirm_pulse && (digit_cnt_q != '0);
   assign timeout    = (timer_q == TmrLast);

   // State and output registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= StIdle;
         digit_cnt_q  <= '0;
         timer_q      <= '0;
         conv_data_q  <= '0;
         show_word_q  <= '0;
         show_mask_q  <= '0;
         error_q      <= 1'b0;
         busy_q       <= 1'b0;
         conv_start_q <= 1'b0;
         conv_reset_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         digit_cnt_q  <= digit_cnt_d;
         timer_q      <= timer_d;
         conv_data_q  <= conv_data_d;
         show_word_q  <= show_word_d;
         show_mask_q  <= show_mask_d;
         error_q      <= error_d;
         busy_q       <= busy_d;
         conv_start_q <= conv_start_d;
         conv_reset_q <= conv_reset_d;
      end
   end

   // Next-state logic; clear_pulse overrides everything.
   always_comb begin
      state_d = state_q;
      if (clear_pulse) begin
         state_d = StIdle;
      end else begin
         case (state_q)
            StIdle: begin
               if (enter_pulse) state_d = StEntry;
            end
            StEntry: begin
               if (confirm_ok) state_d = StStart;
            end
            StStart: state_d = StBusy;
            StBusy: begin
               if (conv.conv_error)     state_d = StFault;
               else if (conv.conv_done) state_d = StShow;
               else if (timeout)        state_d = StFault;
            end
            StShow:  state_d = StShow;
            StFault: state_d = StFault;
            default: state_d = StIdle;
         endcase
      end
   end

   // Output and datapath next values
   always_comb begin
      digit_cnt_d  = digit_cnt_q;
      timer_d      = timer_q;
      conv_data_d  = conv_data_q;
      show_word_d  = show_word_q;
      show_mask_d  = show_mask_q;
      error_d      = error_q;
      conv_reset_d = clear_pulse;
      // Registered strobes follow the state they belong to.
      conv_start_d = (state_d == StStart);
      busy_d       = (state_d == StStart) || (state_d == StBusy);

      if (clear_pulse) begin
         digit_cnt_d = '0;
         timer_d     = '0;
         conv_data_d = '0;
         show_word_d = '0;
         error_d     = 1'b0;
      end else begin
         case (state_q)
            StIdle, StEntry: begin
               show_word_d = entry_word;
               show_mask_d = entry_mask;
               if ((state_q == StEntry) && confirm_ok) begin
                  conv_data_d = entry_word[15:0];
               end else if (enter_pulse && (digit_cnt_q != CntMax)) begin
                  digit_cnt_d = digit_cnt_q + CntW'(1);
               end
            end
            StStart: begin
               timer_d = '0;
            end
            StBusy: begin
               // Exit is forced at TmrLast, so the timer tops out at TIMEOUT_CYCLES.
               timer_d = timer_q + TmrW'(1);
               if (conv.conv_error) begin
                  error_d = 1'b1;
               end else if (conv.conv_done) begin
                  show_word_d = {16'h0000, conv.conv_result};
                  show_mask_d = SHOW_MASK;
               end else if (timeout) begin
                  error_d = 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign conv.conv_start = conv_start_q;
   assign conv.conv_data  = conv_data_q;
   assign conv.conv_reset = conv_reset_q;
   assign show_word       = show_word_q;
   assign show_mask       = show_mask_q;
   assign error           = error_q;
   assign busy            = busy_q;
   assign state           = state_q;

endmodule
